// File: rtl/slow_clk_meter_pkg.sv
// Shared types and default constants for the slow clock period meter.
package slow_clk_meter_pkg;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 27;
  localparam int DEF_TIMEOUT     = 100_000_000;

endpackage

// File: rtl/slow_clk_meter_if.sv
// Signal bundle between the meter and its user.
//
// Handshake: there is no backpressure. valid is a one-cycle pulse that marks
// the cycle in which period carries a freshly measured value; a consumer that
// wants the value must capture period in that cycle. period itself also holds
// its value until the next measurement. timeout and measuring are levels.
interface slow_clk_meter_if
  import slow_clk_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             timeout;
  logic             measuring;
  state_t           dbg_state;

  // User side: drives enable and the signal to measure.
  modport master (
    output en, sig_in,
    input  period, valid, timeout, measuring, dbg_state
  );

  // Meter side.
  modport slave (
    input  en, sig_in,
    output period, valid, timeout, measuring, dbg_state
  );
endinterface

// File: rtl/slow_clk_meter_sync_edge_det.sv
// Synchronizer chain for an asynchronous input followed by a rising-edge
// detector. rise is high for one cycle per synchronized low-to-high change.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_d;

  // Shift the raw input through the synchronizer, then delay it once more
  // so the edge detector compares two settled samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      synced_d <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], d};
      synced_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~synced_d;

endmodule

// File: rtl/slow_clk_meter.sv
// Measures the rising-edge-to-rising-edge period of a slow asynchronous
// signal in clk cycles. The first edge after arming only starts the count;
// each later edge publishes the count and restarts it. A gap longer than
// TIMEOUT cycles raises a sticky timeout and re-arms.
module slow_clk_meter
  import slow_clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  slow_clk_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] period_q, period_n;
  logic             valid_q, valid_n;
  logic             timeout_q, timeout_n;
  logic             measuring_q;
  logic             rise;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.sig_in),
    .rise (rise)
  );

  // State and datapath registers; reset clears everything, including any
  // partially accumulated count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      measuring_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      period_q    <= period_n;
      valid_q     <= valid_n;
      timeout_q   <= timeout_n;
      measuring_q <= (state_n == MEASURE);
    end
  end

  // Next-state and datapath decisions. Dropping en wins over an edge; an
  // edge wins over an expiring count so that a gap of exactly TIMEOUT
  // cycles is still a valid measurement.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    period_n  = period_q;
    valid_n   = 1'b0;
    timeout_n = timeout_q;

    case (state)
      IDLE: begin
        cnt_n     = '0;
        timeout_n = 1'b0;
        if (bus.en) state_n = ARM;
      end

      ARM: begin
        if (!bus.en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (rise) begin
          cnt_n   = ONE_C;
          state_n = MEASURE;
        end
      end

      MEASURE: begin
        if (!bus.en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (rise) begin
          period_n  = cnt;
          valid_n   = 1'b1;
          cnt_n     = ONE_C;
          timeout_n = 1'b0;
        end else if (cnt >= TIMEOUT_C) begin
          timeout_n = 1'b1;
          cnt_n     = '0;
          state_n   = ARM;
        end else begin
          cnt_n = cnt + ONE_C;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.period    = period_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.measuring = measuring_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/slow_clk_meter.md
SLOW_CLK_METER -- requirements
Module: slow_clk_meter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on sig_in (minimum 2).
REQ-002 SHALL have parameter CNT_W, default 27, width of the period counter and the period output.
REQ-003 SHALL have parameter TIMEOUT, default 100_000_000, maximum cycles between edges before timeout; must be less than 2^CNT_W.
REQ-004 Port clk  input  1  system clock (50 MHz); the only clock in the block.
REQ-005 Port rst  input  1  reset; synchronous, active-high.
REQ-006 Port en  input  1  measurement enable; level-sensitive.
REQ-007 Port sig_in  input  1  slow divided-clock signal to measure; asynchronous to clk.
REQ-008 Port period  output  CNT_W  last measured rising-edge-to-rising-edge period, in clk cycles.
REQ-009 Port valid  output  1  one-cycle pulse; period updated this cycle.
REQ-010 Port timeout  output  1  sticky flag; no edge seen within TIMEOUT cycles.
REQ-011 Port measuring  output  1  high while state is MEASURE.

Function
REQ-012 sig_in SHALL pass through SYNC_STAGES flops, then one edge-detect flop; edge = synced & ~synced_d.
REQ-013 Latency from sig_in rising (setup met) to internal edge pulse SHALL be SYNC_STAGES+1 clk cycles.
REQ-014 FSM states SHALL be IDLE, ARM, MEASURE.
REQ-015 IDLE: cnt <= 0, timeout <= 0; go to ARM when en=1.
REQ-016 ARM: wait for edge; on edge cnt <= 1, go to MEASURE; no valid pulse from the first edge.
REQ-017 MEASURE, no edge, cnt < TIMEOUT: cnt <= cnt + 1.
REQ-018 MEASURE, edge: period <= cnt, valid <= 1 next cycle, cnt <= 1, timeout <= 0, stay in MEASURE.
REQ-019 Period semantics: edges N cycles apart SHALL yield period = N.
REQ-020 MEASURE, no edge, cnt == TIMEOUT: timeout <= 1, cnt <= 0, go to ARM; period unchanged; no valid.
REQ-021 Simultaneous edge and cnt == TIMEOUT: edge SHALL win and REQ-018 applies.
REQ-022 cnt SHALL never wrap; it saturates at TIMEOUT by REQ-020.
REQ-023 en=0 in any state: next state IDLE; period holds last value; valid 0; en takes priority over edge.
REQ-024 valid SHALL be registered and exactly one cycle wide; back-to-back valids are only possible with period >= 2.
REQ-025 measuring SHALL be registered from the state (state == MEASURE).

Reset
REQ-026 rst=1 at a clock edge SHALL set: state IDLE; cnt 0; period 0; valid 0; timeout 0; measuring 0; synchronizer and edge flops 0.
REQ-027 rst mid-measurement SHALL discard the partial count; no valid is emitted for it.
REQ-028 rst SHALL override en and edge in the same cycle.

Structure
REQ-029 Package slow_clk_meter_pkg SHALL hold:
- FSM state enum (IDLE, ARM, MEASURE)
- default constants for CNT_W and TIMEOUT
REQ-030 Synchronizer plus edge detector SHALL be a sub-module, sync_edge_det (parameter SYNC_STAGES; ports clk, rst, d, rise).
REQ-031 All flops SHALL be clocked by clk only; no derived or gated clocks.

Verification (bench TIMEOUT=50, SYNC_STAGES=2)
REQ-032 Reset then en=1, sig_in square wave with period 10 -> first valid after the 2nd rising edge with period=10; repeated each 10 cycles; measuring=1.
REQ-033 Duty change: high 3, low 17 cycles -> period=20 every valid; duty ignored.
REQ-034 sig_in held low after lock -> timeout=1 exactly 50 cycles after the last counted edge; state ARM; period holds 20. Next two edges 12 apart -> period=12, timeout=0.
REQ-035 Edges exactly 50 apart -> period=50, timeout stays 0 (edge wins).
REQ-036 en dropped mid-period, then re-raised -> no valid while en=0; next valid only after two fresh edges; period holds prior value meanwhile.
REQ-037 rst asserted 5 cycles into a measurement -> all outputs 0 the next cycle; no stale valid after rst releases.
